// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH valid/ready stages with flush and registered occupancy.
// Optional macro PIPE_REG_BUBBLE_ZERO_EN: zero a stage's data whenever its valid bit clears.
module pipe_reg_chain #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid_reg;
  logic [DEPTH-1:0]            valid_next;
  logic [DEPTH-1:0][WIDTH-1:0] data_reg;
  logic [DEPTH-1:0][WIDTH-1:0] data_next;
  logic [DEPTH-1:0]            src_valid;
  logic [DEPTH-1:0][WIDTH-1:0] src_data;
  logic [DEPTH:0]              ready;
  logic [OCC_W-1:0]            occ_reg;
  logic [OCC_W-1:0]            occ_next;

  // Ready ripples back from the output: a stage can take a word if empty or if it drains.
  always_comb begin
    ready = '0;
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = !valid_reg[k] || ready[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_valid[gi] = in_valid;
        assign src_data[gi]  = in_data;
      end else begin : g_body
        assign src_valid[gi] = valid_reg[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
      end

      assign valid_next[gi] = flush ? 1'b0 : (ready[gi] ? src_valid[gi] : valid_reg[gi]);

`ifdef PIPE_REG_BUBBLE_ZERO_EN
      assign data_next[gi] = (flush || (ready[gi] && !src_valid[gi])) ? '0 :
                             (ready[gi] ? src_data[gi] : data_reg[gi]);
`else
      assign data_next[gi] = (!flush && ready[gi] && src_valid[gi]) ? src_data[gi] : data_reg[gi];
`endif
    end
  endgenerate

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + OCC_W'(valid_next[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      data_reg  <= '0;
      occ_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
      occ_reg   <= occ_next;
    end
  end

  // Reset forces ready high even if flush is asserted alongside it.
  assign in_ready  = (ready[0] && !flush) || reset;
  assign out_valid = valid_reg[DEPTH-1] && !flush;
  assign out_data  = data_reg[DEPTH-1];
  assign occupancy = occ_reg;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=3) with an in-order scoreboard.
module tb_pipe_reg_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int occ_model = 0;
  logic [WIDTH-1:0] sb[$];

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and occupancy model, sampled mid-cycle before the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      occ_model = 0;
    end else begin
      int acc;
      int pop;
      logic [WIDTH-1:0] exp_data;
      tests++;
      if (occupancy !== 2'(occ_model)) begin
        fails++;
        $display("FAIL occupancy_model got=%0d want=%0d", occupancy, occ_model);
      end
      acc = (in_valid && in_ready) ? 1 : 0;
      pop = (out_valid && out_ready) ? 1 : 0;
      if (pop == 1) begin
        tests++;
        pops++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected got=%02h want=none", out_data);
        end else begin
          exp_data = sb.pop_front();
          if (out_data !== exp_data) begin
            fails++;
            $display("FAIL sb_order got=%02h want=%02h", out_data, exp_data);
          end else begin
            $display("[TB] out %02h", out_data);
          end
        end
      end
      if (flush) begin
        sb.delete();
        occ_model = 0;
      end else begin
        if (acc == 1) begin
          sb.push_back(in_data);
          $display("[TB] in  %02h", in_data);
        end
        occ_model = occ_model + acc - pop;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a; step();
    in_data = b; step();
    in_data = c; step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #2;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL reset_state got=rdy%b v%b d%02h o%0d want=rdy1 v0 d00 o0",
               in_ready, out_valid, out_data, occupancy);
    end
    step(); step();
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_capture got=o%0d v%b want=o0 v0", occupancy, out_valid);
    end
    // Mid-stream asynchronous reset with two words in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hD1; step();
    in_data = 8'hD2; step();
    in_valid = 1'b0;
    tests++;
    if (occupancy !== 2'd2) begin
      fails++;
      $display("FAIL reset_prefill got=%0d want=2", occupancy);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL reset_async got=v%b d%02h o%0d want=v0 d00 o0", out_valid, out_data, occupancy);
    end
    step();
    reset = 1'b0;
    drain(4);
    tests++;
    if (pops != 0) begin
      fails++;
      $display("FAIL reset_discard got=%0d pops want=0", pops);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_early got=%b want=0", out_valid);
    end
    in_data = 8'h33; step();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      fails++;
      $display("FAIL stream_c3 got=v%b d%02h want=v1 d11", out_valid, out_data);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      fails++;
      $display("FAIL stream_c4 got=v%b d%02h want=v1 d22", out_valid, out_data);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      fails++;
      $display("FAIL stream_c5 got=v%b d%02h want=v1 d33", out_valid, out_data);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL stream_empty got=v%b o%0d want=v0 o0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    int start_pops;
    start_pops = pops;
    fill3(8'hA1, 8'hA2, 8'hA3);
    in_valid = 1'b1; in_data = 8'hA4;
    step();
    tests++;
    if (occupancy !== 2'd3 || in_ready !== 1'b0 || out_data !== 8'hA1) begin
      fails++;
      $display("FAIL bp_full got=o%0d rdy%b d%02h want=o3 rdy0 dA1", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got=%b want=1", in_ready);
    end
    step();
    drain(5);
    tests++;
    if (pops - start_pops != 4 || sb.size() != 0) begin
      fails++;
      $display("FAIL bp_count got=%0d pops want=4", pops - start_pops);
    end
  endtask

  task automatic test_full_push();
    fill3(8'hB1, 8'hB2, 8'hB3);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5C;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fullpush_ready got=%b want=1", in_ready);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (occupancy !== 2'd3 || out_data !== 8'hB2) begin
      fails++;
      $display("FAIL fullpush_occ got=o%0d d%02h want=o3 dB2", occupancy, out_data);
    end
    drain(5);
    tests++;
    if (sb.size() != 0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL fullpush_drain got=%0d left want=0", sb.size());
    end
  endtask

  task automatic test_flush();
    int start_pops;
    logic [WIDTH-1:0] exp_data;
    fill3(8'hC1, 8'hC2, 8'hC3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_comb got=rdy%b v%b want=rdy0 v0", in_ready, out_valid);
    end
    start_pops = pops;
    step();
    flush = 1'b0; in_valid = 1'b0;
`ifdef PIPE_REG_BUBBLE_ZERO_EN
    exp_data = 8'h00;
`else
    exp_data = 8'hC1;
`endif
    tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== exp_data) begin
      fails++;
      $display("FAIL flush_clear got=o%0d v%b d%02h want=o0 v0 d%02h",
               occupancy, out_valid, out_data, exp_data);
    end
    drain(5);
    tests++;
    if (pops != start_pops) begin
      fails++;
      $display("FAIL flush_leak got=%0d pops want=0", pops - start_pops);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 120; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;
    drain(6);
    tests++;
    if (sb.size() != 0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL b2b_drain got=%0d left o%0d want=0 o0", sb.size(), occupancy);
    end
  endtask

  initial begin
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; reset = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_push();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
